// File: rtl/rm_lane_sequencer_pkg.sv
// Shared parameters, alert codes and the sequence configuration table type for the
// runtime-monitor lane sequencer.
package rm_lane_sequencer_pkg;

  localparam int unsigned NUM_LANES         = 5;
  localparam int unsigned NUM_EVENTS        = 10;
  localparam int unsigned NUM_MONITORED_INS = 2;
  localparam int unsigned SEQ_LEN           = 4;
  localparam int unsigned TMO_W             = 8;

  localparam int unsigned EVT_W   = $clog2(NUM_EVENTS);
  localparam int unsigned LANE_W  = $clog2(NUM_LANES);
  localparam int unsigned ITYPE_W = (NUM_MONITORED_INS > 1) ? $clog2(NUM_MONITORED_INS) : 1;
  localparam int unsigned STEP_W  = $clog2(SEQ_LEN);
  localparam int unsigned LEN_W   = STEP_W + 1;

  typedef enum logic [1:0] {
    AlertMatch   = 2'b00,
    AlertSkip    = 2'b01,
    AlertTimeout = 2'b10
  } rm_alert_e;

  typedef logic [NUM_EVENTS-1:0] evt_vec_t;

  typedef struct packed {
    logic [NUM_MONITORED_INS-1:0][SEQ_LEN-1:0][EVT_W-1:0] seq;
    logic [NUM_MONITORED_INS-1:0][LEN_W-1:0]              len;
  } rm_seq_cfg_t;

  // Programmed indices beyond NUM_EVENTS can never fire.
  function automatic logic evt_hit(evt_vec_t vec, logic [EVT_W-1:0] idx);
    return (32'(idx) < NUM_EVENTS) ? vec[idx] : 1'b0;
  endfunction

endpackage

// File: rtl/rm_lane_sequencer_lane_fsm.sv
// One monitor lane: checks its events arrive in the programmed order within the timeout and
// holds a single pending alert for the shared output arbiter.
module rm_lane_fsm
  import rm_lane_sequencer_pkg::*;
(
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0]  vec_i,
  input  logic                                          lane_reset_i,
  input  rm_seq_cfg_t                                   cfg_i,
  input  logic [TMO_W-1:0]                              timeout_i,
  input  logic                                          pop_i,
  output logic                                          pend_valid_o,
  output logic [ITYPE_W-1:0]                            pend_itype_o,
  output rm_alert_e                                     pend_code_o,
  output logic                                          overflow_o
);

  typedef enum logic [0:0] {StIdle, StTrack} state_e;

  state_e                              state_q, state_d;
  logic [ITYPE_W-1:0]                  itype_q, itype_d;
  logic [STEP_W-1:0]                   step_q, step_d;
  logic [TMO_W-1:0]                    timer_q, timer_d;
  logic                                pend_valid_q, pend_valid_d;
  logic [ITYPE_W-1:0]                  pend_itype_q, pend_itype_d;
  rm_alert_e                           pend_code_q, pend_code_d;
  logic                                ovf_q, ovf_d;

  logic                                alert;
  logic [ITYPE_W-1:0]                  alert_itype;
  rm_alert_e                           alert_code;
  logic                                found;
  logic [ITYPE_W-1:0]                  start_t;
  logic                                skip, adv;
  logic [LEN_W-1:0]                    cur_len;
  logic [SEQ_LEN-1:0][EVT_W-1:0]       cur_seq;
  logic [LEN_W-1:0]                    step_inc;
  logic [TMO_W-1:0]                    timer_inc;

  always_comb begin
    state_d     = state_q;
    itype_d     = itype_q;
    step_d      = step_q;
    timer_d     = timer_q;
    alert       = 1'b0;
    alert_itype = itype_q;
    alert_code  = AlertMatch;
    found       = 1'b0;
    start_t     = '0;
    skip        = 1'b0;

    // Descending scan so the lowest matching itype wins.
    for (int t = NUM_MONITORED_INS - 1; t >= 0; t--) begin
      if (cfg_i.len[t] != '0 && evt_hit(vec_i[t], cfg_i.seq[t][0])) begin
        found   = 1'b1;
        start_t = ITYPE_W'(t);
      end
    end

    cur_len = cfg_i.len[itype_q];
    cur_seq = cfg_i.seq[itype_q];
    for (int k = 1; k < SEQ_LEN; k++) begin
      if (k > int'(step_q) && k < int'(cur_len) && evt_hit(vec_i[itype_q], cur_seq[k])) begin
        skip = 1'b1;
      end
    end
    adv       = evt_hit(vec_i[itype_q], cur_seq[step_q]);
    step_inc  = LEN_W'(step_q) + LEN_W'(1);
    timer_inc = timer_q + TMO_W'(1);

    unique case (state_q)
      StIdle: begin
        if (found) begin
          if (cfg_i.len[start_t] == LEN_W'(1)) begin
            alert       = 1'b1;
            alert_itype = start_t;
            alert_code  = AlertMatch;
          end else begin
            state_d = StTrack;
            itype_d = start_t;
            step_d  = STEP_W'(1);
            timer_d = '0;
          end
        end
      end
      StTrack: begin
        if (skip) begin
          alert      = 1'b1;
          alert_code = AlertSkip;
          state_d    = StIdle;
          step_d     = '0;
          timer_d    = '0;
        end else if (adv) begin
          step_d  = step_q + STEP_W'(1);
          timer_d = '0;
          if (step_inc == cur_len) begin
            alert      = 1'b1;
            alert_code = AlertMatch;
            state_d    = StIdle;
            step_d     = '0;
          end
        end else begin
          timer_d = timer_inc;
          if (timeout_i != '0 && timer_inc == timeout_i) begin
            alert      = 1'b1;
            alert_code = AlertTimeout;
            state_d    = StIdle;
            step_d     = '0;
            timer_d    = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (lane_reset_i) begin
      state_d = StIdle;
      step_d  = '0;
      timer_d = '0;
      alert   = 1'b0;
    end
  end

  // A pop in the same cycle frees the slot for a freshly raised alert.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_itype_d = pend_itype_q;
    pend_code_d  = pend_code_q;
    ovf_d        = ovf_q;
    if (pop_i) pend_valid_d = 1'b0;
    if (alert) begin
      if (!pend_valid_q || pop_i) begin
        pend_valid_d = 1'b1;
        pend_itype_d = alert_itype;
        pend_code_d  = alert_code;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      itype_q      <= '0;
      step_q       <= '0;
      timer_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_itype_q <= '0;
      pend_code_q  <= AlertMatch;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      itype_q      <= itype_d;
      step_q       <= step_d;
      timer_q      <= timer_d;
      pend_valid_q <= pend_valid_d;
      pend_itype_q <= pend_itype_d;
      pend_code_q  <= pend_code_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pend_valid_o = pend_valid_q;
  assign pend_itype_o = pend_itype_q;
  assign pend_code_o  = pend_code_q;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/rm_lane_sequencer.sv
// Lane sequencer top: sequence config table, per-lane trackers and a round-robin arbiter
// feeding a registered valid/ready alert port.
module rm_lane_sequencer
  import rm_lane_sequencer_pkg::*;
(
  input  logic                                                          clk_i,
  input  logic                                                          rst_ni,
  input  logic [NUM_LANES-1:0][NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0]   lane_vector_i,
  input  logic [NUM_LANES-1:0]                                          lane_reset_i,
  input  logic                                                          cfg_we_i,
  input  logic [ITYPE_W-1:0]                                            cfg_itype_i,
  input  logic [STEP_W-1:0]                                             cfg_step_i,
  input  logic [EVT_W-1:0]                                              cfg_event_i,
  input  logic                                                          cfg_len_we_i,
  input  logic [LEN_W-1:0]                                              cfg_len_i,
  input  logic [TMO_W-1:0]                                              cfg_timeout_i,
  output logic                                                          alert_valid_o,
  input  logic                                                          alert_ready_i,
  output logic [LANE_W-1:0]                                             alert_lane_o,
  output logic [ITYPE_W-1:0]                                            alert_itype_o,
  output rm_alert_e                                                     alert_code_o,
  output logic [NUM_LANES-1:0]                                          alert_overflow_o
);

  rm_seq_cfg_t                        cfg_q, cfg_d;
  logic [NUM_LANES-1:0]               pend_valid;
  logic [NUM_LANES-1:0][ITYPE_W-1:0]  pend_itype;
  rm_alert_e                          pend_code [NUM_LANES];
  logic [NUM_LANES-1:0]               pop;

  logic                               valid_q, valid_d;
  logic [LANE_W-1:0]                  lane_q, lane_d;
  logic [ITYPE_W-1:0]                 itype_q, itype_d;
  rm_alert_e                          code_q, code_d;
  logic [LANE_W-1:0]                  rr_q, rr_d;

  logic                               load, sel_found;
  logic [LANE_W-1:0]                  sel;
  int unsigned                        idx;

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_we_i)     cfg_d.seq[cfg_itype_i][cfg_step_i] = cfg_event_i;
    if (cfg_len_we_i) cfg_d.len[cfg_itype_i] = cfg_len_i;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rm_lane_fsm u_lane (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .vec_i        (lane_vector_i[l]),
      .lane_reset_i (lane_reset_i[l]),
      .cfg_i        (cfg_q),
      .timeout_i    (cfg_timeout_i),
      .pop_i        (pop[l]),
      .pend_valid_o (pend_valid[l]),
      .pend_itype_o (pend_itype[l]),
      .pend_code_o  (pend_code[l]),
      .overflow_o   (alert_overflow_o[l])
    );
  end

  always_comb begin
    load      = !valid_q || alert_ready_i;
    sel_found = 1'b0;
    sel       = '0;
    idx       = 0;
    pop       = '0;
    valid_d   = valid_q;
    lane_d    = lane_q;
    itype_d   = itype_q;
    code_d    = code_q;
    rr_d      = rr_q;

    for (int i = 0; i < NUM_LANES; i++) begin
      idx = 32'(rr_q) + 32'(i);
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!sel_found && pend_valid[idx]) begin
        sel_found = 1'b1;
        sel       = LANE_W'(idx);
      end
    end

    if (load) begin
      valid_d = sel_found;
      if (sel_found) begin
        pop[sel] = 1'b1;
        lane_d   = sel;
        itype_d  = pend_itype[sel];
        code_d   = pend_code[sel];
        rr_d     = (sel == LANE_W'(NUM_LANES - 1)) ? '0 : sel + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_q   <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      itype_q <= '0;
      code_q  <= AlertMatch;
      rr_q    <= '0;
    end else begin
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      itype_q <= itype_d;
      code_q  <= code_d;
      rr_q    <= rr_d;
    end
  end

  assign alert_valid_o = valid_q;
  assign alert_lane_o  = lane_q;
  assign alert_itype_o = itype_q;
  assign alert_code_o  = code_q;

endmodule

// File: tb/tb_rm_lane_sequencer.sv
// Directed bench for rm_lane_sequencer; expected alerts are queued when stimulus is driven and
// compared at each output handshake.
module tb_rm_lane_sequencer;
  import rm_lane_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                                        rst_ni;
  logic [NUM_LANES-1:0][NUM_MONITORED_INS-1:0][NUM_EVENTS-1:0] lane_vector;
  logic [NUM_LANES-1:0]                                        lane_reset;
  logic                                                        cfg_we, cfg_len_we;
  logic [ITYPE_W-1:0]                                          cfg_itype;
  logic [STEP_W-1:0]                                           cfg_step;
  logic [EVT_W-1:0]                                            cfg_event;
  logic [LEN_W-1:0]                                            cfg_len;
  logic [TMO_W-1:0]                                            cfg_timeout;
  logic                                                        alert_valid, alert_ready;
  logic [LANE_W-1:0]                                           alert_lane;
  logic [ITYPE_W-1:0]                                          alert_itype;
  rm_alert_e                                                   alert_code;
  logic [NUM_LANES-1:0]                                        alert_overflow;

  rm_lane_sequencer dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .lane_vector_i    (lane_vector),
    .lane_reset_i     (lane_reset),
    .cfg_we_i         (cfg_we),
    .cfg_itype_i      (cfg_itype),
    .cfg_step_i       (cfg_step),
    .cfg_event_i      (cfg_event),
    .cfg_len_we_i     (cfg_len_we),
    .cfg_len_i        (cfg_len),
    .cfg_timeout_i    (cfg_timeout),
    .alert_valid_o    (alert_valid),
    .alert_ready_i    (alert_ready),
    .alert_lane_o     (alert_lane),
    .alert_itype_o    (alert_itype),
    .alert_code_o     (alert_code),
    .alert_overflow_o (alert_overflow)
  );

  int         n_vec = 0;
  int         n_mis = 0;
  logic [5:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pk(input int lane, input int itype, input rm_alert_e code);
    return {LANE_W'(lane), ITYPE_W'(itype), 2'(code)};
  endfunction

  // One clock; a handshake seen before the edge is scored against the queue after it.
  task automatic tick();
    logic       hs;
    logic [5:0] cap;
    logic [5:0] exp;
    hs  = alert_valid && alert_ready;
    cap = {alert_lane, alert_itype, 2'(alert_code)};
    @(posedge clk);
    #1;
    if (hs) begin
      if (sb_q.size() == 0) begin
        check("spurious_alert", 32'(cap), 32'hffff_ffff);
      end else begin
        exp = sb_q.pop_front();
        check("alert_handshake", 32'(cap), 32'(exp));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic set_seq(input int it, input int st, input int ev);
    cfg_we    = 1'b1;
    cfg_itype = ITYPE_W'(it);
    cfg_step  = STEP_W'(st);
    cfg_event = EVT_W'(ev);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic set_len(input int it, input int len);
    cfg_len_we = 1'b1;
    cfg_itype  = ITYPE_W'(it);
    cfg_len    = LEN_W'(len);
    tick();
    cfg_len_we = 1'b0;
  endtask

  task automatic fire(input logic [NUM_LANES-1:0] lanes, input int it, input int ev);
    for (int l = 0; l < NUM_LANES; l++) if (lanes[l]) lane_vector[l][it][ev] = 1'b1;
    tick();
    lane_vector = '0;
  endtask

  // itype0 sequence {3,5,7} with a gap cycle between events; ends on the MATCH cycle.
  task automatic match3(input logic [NUM_LANES-1:0] lanes);
    fire(lanes, 0, 3);
    idle(1);
    fire(lanes, 0, 5);
    idle(1);
    fire(lanes, 0, 7);
  endtask

  initial begin
    rst_ni      = 1'b0;
    lane_vector = '0;
    lane_reset  = '0;
    cfg_we      = 1'b0;
    cfg_len_we  = 1'b0;
    cfg_itype   = '0;
    cfg_step    = '0;
    cfg_event   = '0;
    cfg_len     = '0;
    cfg_timeout = '0;
    alert_ready = 1'b1;
    idle(2);
    check("reset_valid", 32'(alert_valid), 32'd0);
    check("reset_lane", 32'(alert_lane), 32'd0);
    check("reset_itype", 32'(alert_itype), 32'd0);
    check("reset_code", 32'(alert_code), 32'd0);
    check("reset_overflow", 32'(alert_overflow), 32'd0);
    rst_ni = 1'b1;

    set_seq(0, 0, 3);
    set_seq(0, 1, 5);
    set_seq(0, 2, 7);
    set_len(0, 3);

    // Simultaneous MATCH on lanes 0,3,4 from RR pointer 0.
    match3(5'b11001);
    check("sim_not_yet", 32'(alert_valid), 32'd0);
    sb_q.push_back(pk(0, 0, AlertMatch));
    sb_q.push_back(pk(3, 0, AlertMatch));
    sb_q.push_back(pk(4, 0, AlertMatch));
    tick();
    check("sim_valid0", 32'(alert_valid), 32'd1);
    tick();
    check("sim_valid1", 32'(alert_valid), 32'd1);
    tick();
    check("sim_valid2", 32'(alert_valid), 32'd1);
    tick();
    check("sim_drained", 32'(alert_valid), 32'd0);

    // Pointer wrapped to 0 after lane4: lane1 is served before lane4.
    match3(5'b10010);
    sb_q.push_back(pk(1, 0, AlertMatch));
    sb_q.push_back(pk(4, 0, AlertMatch));
    idle(4);

    // In-order lane2 with two-cycle alert latency.
    match3(5'b00100);
    check("inorder_latency1", 32'(alert_valid), 32'd0);
    sb_q.push_back(pk(2, 0, AlertMatch));
    tick();
    check("inorder_latency2", 32'(alert_valid), 32'd1);
    check("inorder_lane", 32'(alert_lane), 32'd2);
    idle(2);

    // Skip on lane1; the following event 5 is ignored in IDLE.
    fire(5'b00010, 0, 3);
    sb_q.push_back(pk(1, 0, AlertSkip));
    fire(5'b00010, 0, 7);
    fire(5'b00010, 0, 5);
    check("skip_latency", 32'(alert_valid), 32'd1);
    check("skip_code", 32'(alert_code), 32'(AlertSkip));
    idle(4);
    check("skip_no_extra", 32'(alert_valid), 32'd0);

    // Timeout of 4 idle cycles on lane0.
    cfg_timeout = 8'd4;
    fire(5'b00001, 0, 3);
    idle(4);
    check("tmo_not_yet", 32'(alert_valid), 32'd0);
    sb_q.push_back(pk(0, 0, AlertTimeout));
    tick();
    check("tmo_valid", 32'(alert_valid), 32'd1);
    idle(2);

    // Lane reset mid-sequence suppresses both advance and timeout.
    fire(5'b00001, 0, 3);
    idle(1);
    lane_reset[0] = 1'b1;
    tick();
    lane_reset = '0;
    idle(8);
    check("lane_reset_quiet", 32'(alert_valid), 32'd0);
    cfg_timeout = '0;

    // Backpressure: three single-step MATCHes on lane2 with ready low.
    set_seq(1, 0, 2);
    set_len(1, 1);
    alert_ready = 1'b0;
    lane_vector[2][1][2] = 1'b1;
    idle(3);
    lane_vector = '0;
    sb_q.push_back(pk(2, 1, AlertMatch));
    sb_q.push_back(pk(2, 1, AlertMatch));
    check("bp_overflow", 32'(alert_overflow), 32'h04);
    check("bp_valid", 32'(alert_valid), 32'd1);
    check("bp_lane", 32'(alert_lane), 32'd2);
    check("bp_itype", 32'(alert_itype), 32'd1);
    idle(3);
    check("bp_stable_valid", 32'(alert_valid), 32'd1);
    check("bp_stable_fields", 32'({alert_lane, alert_itype, 2'(alert_code)}),
          32'(pk(2, 1, AlertMatch)));
    alert_ready = 1'b1;
    tick();
    check("bp_second", 32'(alert_valid), 32'd1);
    tick();
    check("bp_empty", 32'(alert_valid), 32'd0);
    check("bp_overflow_sticky", 32'(alert_overflow), 32'h04);

    // Disabled itype1 produces nothing.
    set_len(1, 0);
    fire(5'b01000, 1, 2);
    idle(3);
    check("disabled_itype", 32'(alert_valid), 32'd0);

    // Reprogram step 1 to event 6 while lane0 is tracking.
    fire(5'b00001, 0, 3);
    set_seq(0, 1, 6);
    fire(5'b00001, 0, 6);
    fire(5'b00001, 0, 7);
    check("reconf_not_yet", 32'(alert_valid), 32'd0);
    sb_q.push_back(pk(0, 0, AlertMatch));
    tick();
    check("reconf_valid", 32'(alert_valid), 32'd1);
    idle(3);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
